btn_int_conditioner: RTL and testbench

//  Conditions raw board push-buttons (BTNC/U/L/R/D) into clean CPU interrupt requests.

---
 rtl/cpu_io_pkg.sv | 21 ++
 rtl/btn_debounce_ch.sv | 76 +++++++
 rtl/btn_int_conditioner.sv | 40 ++++
 tb/tb_btn_int_conditioner.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared constants and helpers for the CPU I/O blocks: button/interrupt counts,
// debounce and pulse defaults, and the debounce terminal-count calculation.
package cpu_io_pkg;

    localparam int N_BTN = 5;
    localparam int N_INT = 7;

    localparam int DEFAULT_CLK_HZ       = 100_000_000;
    localparam int DEFAULT_DEBOUNCE_MS  = 10;
    localparam int DEFAULT_PULSE_CYCLES = 4;

    // Pulse stretch counter width; bounds PULSE_CYCLES to 1..255.
    localparam int PULSE_W         = 8;
    localparam int PULSE_MAX_CYCLE = (1 << PULSE_W) - 1;

    // Number of clocks a new level must hold before it is accepted.
    function automatic int calc_cnt_max(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, counter debounce, rising-edge detect
// and a fixed-width interrupt pulse stretcher.
module btn_debounce_ch
    import cpu_io_pkg::*;
#(
    parameter int CNT_MAX      = 4,
    parameter int PULSE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CNT_MAX - 1);
    localparam logic [PULSE_W-1:0] PULSE_LEN = PULSE_W'(PULSE_CYCLES);

    logic [1:0]         sync_q;
    logic               btn_s;
    logic               stable_q, stable_d;
    logic               stable_dly_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PULSE_W-1:0] pcnt_q, pcnt_d;
    logic               rise;

    assign btn_s = sync_q[1];
    assign rise  = stable_q & ~stable_dly_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, whatever order the statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
            pcnt_q       <= '0;
        end else begin
            sync_q       <= {sync_q[0], btn_i};
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            pcnt_q       <= pcnt_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the branches can leave a value held and infer a latch.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        pcnt_d   = pcnt_q;

        // Any return to the stable level drops the count: no partial credit.
        if (btn_s != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = btn_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A rise during an active stretch reloads rather than queues.
        if (rise) begin
            pcnt_d = PULSE_LEN;
        end else if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - PULSE_W'(1);
        end
    end

    assign level_o = stable_q;
    assign pulse_o = (pcnt_q != '0);

endmodule

// File: rtl/btn_int_conditioner.sv
// Turns raw push-button pins into debounced levels and stretched interrupt
// pulses, one independent btn_debounce_ch per button.
module btn_int_conditioner
    import cpu_io_pkg::*;
#(
    parameter int N_CH         = N_BTN,
    parameter int CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int DEBOUNCE_MS  = DEFAULT_DEBOUNCE_MS,
    parameter int PULSE_CYCLES = DEFAULT_PULSE_CYCLES
) (
    input  logic            CLK100MHZ,
    input  logic            CPU_RESETN,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] btn_level_o,
    output logic [N_CH-1:0] int_pulse_o
);

    localparam int CNT_MAX = calc_cnt_max(CLK_HZ, DEBOUNCE_MS);

    if (CNT_MAX < 1) begin : g_bad_cnt_max
        $error("btn_int_conditioner: CNT_MAX must be >= 1");
    end
    if ((PULSE_CYCLES < 1) || (PULSE_CYCLES > PULSE_MAX_CYCLE)) begin : g_bad_pulse
        $error("btn_int_conditioner: PULSE_CYCLES must be in 1..255");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .CNT_MAX      (CNT_MAX),
            .PULSE_CYCLES (PULSE_CYCLES)
        ) u_ch (
            .clk     (CLK100MHZ),
            .rst_n   (CPU_RESETN),
            .btn_i   (btn_i[i]),
            .level_o (btn_level_o[i]),
            .pulse_o (int_pulse_o[i])
        );
    end

endmodule

// File: tb/tb_btn_int_conditioner.sv
// Directed bench for btn_int_conditioner with CNT_MAX=4, PULSE_CYCLES=3:
// press latency, bounce rejection, release, simultaneous presses, reset.
module tb_btn_int_conditioner;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn;
    logic [4:0] level;
    logic [4:0] pulse;

    int n_vec  = 0;
    int n_miss = 0;

    btn_int_conditioner #(
        .N_CH         (5),
        .CLK_HZ       (1000),
        .DEBOUNCE_MS  (4),
        .PULSE_CYCLES (3)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .btn_i       (btn),
        .btn_level_o (level),
        .int_pulse_o (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller has just changed btn so that bits in mask rise; hold holds the
    // level of unrelated channels. Level follows 6 clks later, pulse 7..9.
    task automatic rise_window(input string tag, input logic [4:0] hold, input logic [4:0] mask);
        for (int t = 1; t <= 10; t++) begin
            tick();
            check($sformatf("%s_lvl_t%0d", tag, t), level, (t >= 6) ? (hold | mask) : hold);
            check($sformatf("%s_int_t%0d", tag, t), pulse, (t >= 7 && t <= 9) ? mask : 5'h00);
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // 1: reset held with all buttons pressed
        rst_n = 1'b0;
        btn   = 5'h1F;
        #1;
        check("rst_lvl_async", level, 5'h00);
        check("rst_int_async", pulse, 5'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_lvl", level, 5'h00);
            check("rst_int", pulse, 5'h00);
        end
        rst_n = 1'b1;
        rise_window("post_rst", 5'h00, 5'h1F);

        btn = 5'h00;
        settle(8);
        check("all_released", level, 5'h00);

        // 2: clean press on channel 0
        btn = 5'h01;
        rise_window("clean0", 5'h00, 5'h01);
        btn = 5'h00;
        settle(8);
        check("clean0_released", level, 5'h00);

        // 3: bounce 1,0,1 with 2-clk gaps, then held; final 0->1 at t=4
        btn = 5'h01;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 2) btn = 5'h00;
            if (t == 4) btn = 5'h01;
            check($sformatf("bounce_lvl_t%0d", t), level, (t >= 10) ? 5'h01 : 5'h00);
            check($sformatf("bounce_int_t%0d", t), pulse, (t >= 11 && t <= 13) ? 5'h01 : 5'h00);
        end

        // 4: release of channel 1 gives a falling level and no pulse
        btn = 5'h03;
        settle(12);
        check("rel1_held", level, 5'h03);
        btn = 5'h01;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check($sformatf("rel1_lvl_t%0d", t), level, (t < 6) ? 5'h03 : 5'h01);
            check($sformatf("rel1_int_t%0d", t), pulse, 5'h00);
        end

        // 5: simultaneous press on channels 0, 2, 4
        btn = 5'h00;
        settle(8);
        check("sim_idle", level, 5'h00);
        btn = 5'h15;
        rise_window("sim", 5'h00, 5'h15);

        // 6: reset asserted on clock 2 of a stretch, button kept pressed
        btn = 5'h00;
        settle(8);
        check("mid_idle", level, 5'h00);
        btn = 5'h01;
        settle(8);
        check("mid_pre_lvl", level, 5'h01);
        check("mid_pre_int", pulse, 5'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_lvl", level, 5'h00);
        check("mid_rst_int", pulse, 5'h00);
        settle(2);
        check("mid_rst_hold_lvl", level, 5'h00);
        check("mid_rst_hold_int", pulse, 5'h00);
        rst_n = 1'b1;
        rise_window("mid_requal", 5'h00, 5'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
